dp_ram_arbiter: RTL and testbench

DP_RAM_ARBITER -- requirements
Module: dp_ram_arbiter

---
 rtl/dp_ram_arb_pkg.sv | 28 ++
 rtl/dp_ram_arbiter_rr_pick2.sv | 43 ++++
 rtl/dp_ram_arbiter.sv | 130 +++++++++++++
 tb/tb_dp_ram_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_arb_pkg.sv
// Shared types for the dual-port RAM arbiter: RAM port selector and the
// read-return tag that travels with each RAM command.
package dp_ram_arb_pkg;

    localparam int ID_W = 3;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        port_e           port;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, id: '0, port: PORT_A};

    function automatic logic tag_hit(input tag_t t, input logic [ID_W-1:0] id);
        return t.valid && (t.id == id);
    endfunction

    function automatic logic [31:0] tag_dummy_unused(input logic [31:0] x);
        return x;
    endfunction

endpackage

// File: rtl/dp_ram_arbiter_rr_pick2.sv
// Combinational round-robin picker: first requester at/after ptr wins A,
// the next requester after it (circularly) wins B.
module rr_pick2
    import dp_ram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx_a,
    output logic [IW-1:0]   idx_b,
    output logic            valid_a,
    output logic            valid_b
);

    int              j;
    logic [NREQ-1:0] onehot;

    always_comb begin
        idx_a   = '0;
        idx_b   = '0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        j       = 0;
        onehot  = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            onehot = {{(NREQ-1){1'b0}}, 1'b1} << j;
            if ((req & onehot) != '0) begin
                if (!valid_a) begin
                    valid_a = 1'b1;
                    idx_a   = IW'(j);
                end else if (!valid_b) begin
                    valid_b = 1'b1;
                    idx_b   = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Arbitrates NREQ requesters onto the two ports of an external dual-port RAM
// and routes the one-cycle-latency read data back through a tag pipeline.
module dp_ram_arbiter
    import dp_ram_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DPRAM_AW = 10,
    parameter int DPRAM_DW = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ*DPRAM_AW-1:0] adr_i,
    input  logic [NREQ*DPRAM_DW-1:0] wdat_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          rvalid_o,
    output logic [NREQ*DPRAM_DW-1:0] rdat_o,
    output logic                     cyc_a_o,
    output logic                     we_a_o,
    output logic [DPRAM_AW-1:0]      adr_a_o,
    output logic [DPRAM_DW-1:0]      dat_a_o,
    output logic                     cyc_b_o,
    output logic                     we_b_o,
    output logic [DPRAM_AW-1:0]      adr_b_o,
    output logic [DPRAM_DW-1:0]      dat_b_o,
    input  logic [DPRAM_DW-1:0]      dat_a_i,
    input  logic [DPRAM_DW-1:0]      dat_b_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]       rr_ptr, idx_a, idx_b;
    logic                valid_a, valid_b, collide, grant_b;
    tag_t                tag_a_p0, tag_b_p0, tag_a_p1, tag_b_p1;
    logic [DPRAM_AW-1:0] adr_arr  [NREQ];
    logic [DPRAM_DW-1:0] wdat_arr [NREQ];

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        return (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [DPRAM_DW-1:0] pick_dat(input port_e p,
                                                      input logic [DPRAM_DW-1:0] da,
                                                      input logic [DPRAM_DW-1:0] db);
        return (p == PORT_B) ? db : da;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign adr_arr[g]  = adr_i[g*DPRAM_AW +: DPRAM_AW];
        assign wdat_arr[g] = wdat_i[g*DPRAM_DW +: DPRAM_DW];
    end

    rr_pick2 #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (req_i),
        .ptr     (rr_ptr),
        .idx_a   (idx_a),
        .idx_b   (idx_b),
        .valid_a (valid_a),
        .valid_b (valid_b)
    );

    // Two writes to one address would race inside the RAM, so B backs off.
    assign collide = we_i[idx_a] && we_i[idx_b] && (adr_arr[idx_a] == adr_arr[idx_b]);
    assign grant_b = valid_b && !collide;

    always_comb begin
        gnt_o = '0;
        if (!rst) begin
            if (valid_a) gnt_o[idx_a] = 1'b1;
            if (grant_b) gnt_o[idx_b] = 1'b1;
        end
    end

    // p0: command registered onto the RAM ports, tag captured alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            cyc_a_o  <= 1'b0;
            cyc_b_o  <= 1'b0;
            tag_a_p0 <= TAG_IDLE;
            tag_b_p0 <= TAG_IDLE;
            tag_a_p1 <= TAG_IDLE;
            tag_b_p1 <= TAG_IDLE;
        end else begin
            cyc_a_o  <= valid_a;
            cyc_b_o  <= grant_b;
            tag_a_p0 <= '{valid: valid_a && !we_i[idx_a], id: ID_W'(idx_a), port: PORT_A};
            tag_b_p0 <= '{valid: grant_b && !we_i[idx_b], id: ID_W'(idx_b), port: PORT_B};
            // p1: tag aligned with the RAM read data
            tag_a_p1 <= tag_a_p0;
            tag_b_p1 <= tag_b_p0;
            if (grant_b)      rr_ptr <= wrap_inc(idx_b);
            else if (valid_a) rr_ptr <= wrap_inc(idx_a);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_a_o  <= 1'b0;
            adr_a_o <= '0;
            dat_a_o <= '0;
            we_b_o  <= 1'b0;
            adr_b_o <= '0;
            dat_b_o <= '0;
        end else begin
            if (valid_a) begin
                we_a_o  <= we_i[idx_a];
                adr_a_o <= adr_arr[idx_a];
                dat_a_o <= wdat_arr[idx_a];
            end
            if (grant_b) begin
                we_b_o  <= we_i[idx_b];
                adr_b_o <= adr_arr[idx_b];
                dat_b_o <= wdat_arr[idx_b];
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_route
        logic hit_a, hit_b;
        assign hit_a       = tag_hit(tag_a_p1, ID_W'(g));
        assign hit_b       = tag_hit(tag_b_p1, ID_W'(g));
        assign rvalid_o[g] = hit_a || hit_b;
        assign rdat_o[g*DPRAM_DW +: DPRAM_DW] =
            hit_a ? pick_dat(tag_a_p1.port, dat_a_i, dat_b_i) :
            hit_b ? pick_dat(tag_b_p1.port, dat_a_i, dat_b_i) : '0;
    end

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Bench for dp_ram_arbiter: RAM model with forwarding, read-data scoreboard,
// and one task per scenario.
module tb_dp_ram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_i, we_i;
    logic [NREQ*AW-1:0]   adr_i;
    logic [NREQ*DW-1:0]   wdat_i;
    logic [NREQ-1:0]      gnt_o, rvalid_o;
    logic [NREQ*DW-1:0]   rdat_o;
    logic                 cyc_a_o, we_a_o, cyc_b_o, we_b_o;
    logic [AW-1:0]        adr_a_o, adr_b_o;
    logic [DW-1:0]        dat_a_o, dat_b_o, dat_a_i, dat_b_i;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t            sb[$];
    int              n_tests, n_fail, cyc;
    int              rv_cnt [NREQ];
    int              rv_base [NREQ];
    logic [NREQ-1:0] acc_q;
    logic            auto_drop;
    logic [DW-1:0]   mem    [0:1023];
    logic [DW-1:0]   shadow [0:1023];

    dp_ram_arbiter #(.NREQ(NREQ), .DPRAM_AW(AW), .DPRAM_DW(DW)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .adr_i(adr_i), .wdat_i(wdat_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdat_o(rdat_o),
        .cyc_a_o(cyc_a_o), .we_a_o(we_a_o), .adr_a_o(adr_a_o), .dat_a_o(dat_a_o),
        .cyc_b_o(cyc_b_o), .we_b_o(we_b_o), .adr_b_o(adr_b_o), .dat_b_o(dat_b_o),
        .dat_a_i(dat_a_i), .dat_b_i(dat_b_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // RAM model: registered read, write-to-read forwarding across ports
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        dat_a_i = '0;
        dat_b_i = '0;
        forever begin
            @(posedge clk);
            if (cyc_a_o && !we_a_o)
                dat_a_i <= (cyc_b_o && we_b_o && adr_b_o == adr_a_o) ? dat_b_o : mem[adr_a_o];
            if (cyc_b_o && !we_b_o)
                dat_b_i <= (cyc_a_o && we_a_o && adr_a_o == adr_b_o) ? dat_a_o : mem[adr_b_o];
            if (cyc_a_o && we_a_o) mem[adr_a_o] = dat_a_o;
            if (cyc_b_o && we_b_o) mem[adr_b_o] = dat_b_o;
        end
    end

    // Scoreboard: push on acceptance, pop on rvalid
    initial begin
        logic [AW-1:0] a;
        logic          found;
        for (int i = 0; i < 1024; i++) shadow[i] = '0;
        for (int k = 0; k < NREQ; k++) rv_cnt[k] = 0;
        acc_q = '0;
        forever begin
            @(negedge clk);
            acc_q = req_i & gnt_o;
            if (rst) sb.delete();
            for (int k = 0; k < NREQ; k++) begin
                a = adr_i[k*AW +: AW];
                if (acc_q[k] && we_i[k]) shadow[a] = wdat_i[k*DW +: DW];
            end
            for (int k = 0; k < NREQ; k++) begin
                a = adr_i[k*AW +: AW];
                if (acc_q[k] && !we_i[k]) sb.push_back('{id: k, data: shadow[a], due: cyc + 2});
            end
            for (int k = 0; k < NREQ; k++) begin
                n_tests++;
                if (rvalid_o[k]) begin
                    rv_cnt[k]++;
                    found = 1'b0;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (!found && sb[i].id == k && sb[i].due == cyc) begin
                            found = 1'b1;
                            if (rdat_o[k*DW +: DW] !== sb[i].data) begin
                                n_fail++;
                                $display("FAIL rdat[%0d] cycle %0d: got %h expected %h",
                                         k, cyc, rdat_o[k*DW +: DW], sb[i].data);
                            end
                            sb.delete(i);
                        end
                    end
                    if (!found) begin
                        n_fail++;
                        $display("FAIL unexpected_rvalid[%0d] cycle %0d: got 1 expected 0", k, cyc);
                    end
                end else if (rdat_o[k*DW +: DW] !== '0) begin
                    n_fail++;
                    $display("FAIL rdat_idle[%0d]: got %h expected 0", k, rdat_o[k*DW +: DW]);
                end
            end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due < cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_rvalid[%0d] due %0d: got 0 expected 1", sb[i].id, sb[i].due);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req_i = req_i & ~acc_q;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        req_i[k] = 1'b1;
        we_i[k]  = 1'b0;
        adr_i[k*AW +: AW] = a;
    endtask

    task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_i[k] = 1'b1;
        we_i[k]  = 1'b1;
        adr_i[k*AW +: AW] = a;
        wdat_i[k*DW +: DW] = d;
    endtask

    task automatic write1(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_wr(k, a, d);
        @(negedge clk);
        tick();
        tick();
    endtask

    task automatic reset_dut();
        req_i = '0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        req_i = '1;
        we_i  = '0;
        @(negedge clk);
        n_tests++;
        if (gnt_o !== '0 || cyc_a_o !== 1'b0 || cyc_b_o !== 1'b0 || we_a_o !== 1'b0 ||
            we_b_o !== 1'b0 || adr_a_o !== '0 || adr_b_o !== '0 || dat_a_o !== '0 ||
            dat_b_o !== '0 || rvalid_o !== '0 || rdat_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b cyc=%b%b adr=%h/%h rvalid=%b expected all zero",
                     gnt_o, cyc_a_o, cyc_b_o, adr_a_o, adr_b_o, rvalid_o);
        end
        reset_dut();
    endtask

    task automatic test_write_read();
        reset_dut();
        set_wr(0, 10'h010, 32'hDEADBEEF);
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b0001) begin
            n_fail++; $display("FAIL wr_gnt: got %b expected 0001", gnt_o);
        end
        tick();
        set_rd(0, 10'h010);
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b0001) begin
            n_fail++; $display("FAIL rd_gnt: got %b expected 0001", gnt_o);
        end
        n_tests++;
        if (cyc_a_o !== 1'b1 || we_a_o !== 1'b1 || adr_a_o !== 10'h010 ||
            dat_a_o !== 32'hDEADBEEF || cyc_b_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_port_a: got cyc=%b we=%b adr=%h dat=%h cyc_b=%b expected 1 1 010 deadbeef 0",
                     cyc_a_o, we_a_o, adr_a_o, dat_a_o, cyc_b_o);
        end
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        n_tests++;
        if (cyc_a_o !== 1'b0 || we_a_o !== 1'b0 || adr_a_o !== 10'h010) begin
            n_fail++;
            $display("FAIL idle_hold_a: got cyc=%b we=%b adr=%h expected 0 0 010", cyc_a_o, we_a_o, adr_a_o);
        end
        wait_drain("write_read");
    endtask

    task automatic test_dual_read();
        write1(1, 10'h011, 32'h1234_5678);
        reset_dut();
        set_rd(1, 10'h010);
        set_rd(2, 10'h011);
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b0110) begin
            n_fail++; $display("FAIL dual_gnt: got %b expected 0110", gnt_o);
        end
        tick();
        for (int k = 0; k < NREQ; k++) set_rd(k, 10'h010 + AW'(k));
        @(negedge clk);
        n_tests++;
        if (cyc_a_o !== 1'b1 || adr_a_o !== 10'h010 || cyc_b_o !== 1'b1 || adr_b_o !== 10'h011 ||
            we_a_o !== 1'b0 || we_b_o !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_ports: got a=%b/%h b=%b/%h expected 1/010 1/011",
                     cyc_a_o, adr_a_o, cyc_b_o, adr_b_o);
        end
        n_tests++;
        if (gnt_o !== 4'b1001) begin
            n_fail++; $display("FAIL ptr3_gnt: got %b expected 1001", gnt_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (adr_a_o !== 10'h013 || adr_b_o !== 10'h010) begin
            n_fail++; $display("FAIL ptr3_order: got a=%h b=%h expected 013 010", adr_a_o, adr_b_o);
        end
        n_tests++;
        if (gnt_o !== 4'b0110) begin
            n_fail++; $display("FAIL ptr1_gnt: got %b expected 0110", gnt_o);
        end
        tick();
        req_i = '0;
        wait_drain("dual_read");
    endtask

    task automatic test_write_collision();
        reset_dut();
        set_wr(0, 10'h020, 32'hAAAA_0000);
        set_wr(3, 10'h020, 32'hBBBB_3333);
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b0001) begin
            n_fail++; $display("FAIL coll_gnt0: got %b expected 0001", gnt_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b1000) begin
            n_fail++; $display("FAIL coll_gnt3: got %b expected 1000", gnt_o);
        end
        n_tests++;
        if (cyc_a_o !== 1'b1 || cyc_b_o !== 1'b0) begin
            n_fail++; $display("FAIL coll_ports: got cyc_a=%b cyc_b=%b expected 1 0", cyc_a_o, cyc_b_o);
        end
        tick();
        set_rd(1, 10'h020);
        @(negedge clk);
        tick();
        wait_drain("collision");
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_g;
        reset_dut();
        for (int k = 0; k < NREQ; k++) rv_base[k] = rv_cnt[k];
        auto_drop = 1'b0;
        for (int k = 0; k < NREQ; k++) set_rd(k, 10'h010 + AW'(k));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            n_tests++;
            if (gnt_o !== exp_g) begin
                n_fail++; $display("FAIL fair_gnt c%0d: got %b expected %b", c, gnt_o, exp_g);
            end
            tick();
        end
        req_i = '0;
        auto_drop = 1'b1;
        wait_drain("fairness");
        for (int k = 0; k < NREQ; k++) begin
            n_tests++;
            if (rv_cnt[k] - rv_base[k] != 4) begin
                n_fail++;
                $display("FAIL fair_rvalids[%0d]: got %0d expected 4", k, rv_cnt[k] - rv_base[k]);
            end
        end
    endtask

    task automatic test_read_during_write();
        reset_dut();
        set_wr(0, 10'h030, 32'h0000_0005);
        set_rd(1, 10'h030);
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b0011) begin
            n_fail++; $display("FAIL rdw_gnt: got %b expected 0011", gnt_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (!(cyc_a_o && we_a_o && adr_a_o == 10'h030 && dat_a_o == 32'h5 &&
              cyc_b_o && !we_b_o && adr_b_o == 10'h030)) begin
            n_fail++;
            $display("FAIL rdw_ports: got a=%b%b/%h/%h b=%b%b/%h expected 11/030/5 10/030",
                     cyc_a_o, we_a_o, adr_a_o, dat_a_o, cyc_b_o, we_b_o, adr_b_o);
        end
        tick();
        wait_drain("rdw");
    endtask

    task automatic test_reset_mid_read();
        reset_dut();
        set_rd(2, 10'h010);
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b0100) begin
            n_fail++; $display("FAIL midrst_gnt: got %b expected 0100", gnt_o);
        end
        tick();
        rst = 1'b1;
        set_rd(1, 10'h011);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (rvalid_o !== '0 || gnt_o !== '0 || cyc_a_o !== 1'b0 || cyc_b_o !== 1'b0 ||
                adr_a_o !== '0 || dat_a_o !== '0 || we_a_o !== 1'b0 || rdat_o !== '0) begin
                n_fail++;
                $display("FAIL midrst_outputs c%0d: got rvalid=%b gnt=%b cyc=%b%b adr_a=%h expected all zero",
                         c, rvalid_o, gnt_o, cyc_a_o, cyc_b_o, adr_a_o);
            end
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) set_rd(k, 10'h010 + AW'(k));
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b0011) begin
            n_fail++; $display("FAIL midrst_ptr0: got %b expected 0011", gnt_o);
        end
        tick();
        req_i = '0;
        wait_drain("reset_mid_read");
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        auto_drop = 1'b1;
        rst       = 1'b1;
        req_i     = '0;
        we_i      = '0;
        adr_i     = '0;
        wdat_i    = '0;
        test_reset();
        test_write_read();
        test_dual_read();
        test_write_collision();
        test_fairness();
        test_read_during_write();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
